// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter driving a shared 4:1 mux SELECT.
// Optional hold-limit preemption is built when ARB_HOLD_LIMIT_EN is defined.
module rr_arbiter_4
`ifdef ARB_HOLD_LIMIT_EN
#(
    parameter int MAX_HOLD  = 8,
    parameter int CNT_WIDTH = 4
)
`endif
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] REQUEST,
    output logic [3:0] GRANT,
    output logic [1:0] SELECT,
    output logic       BUSY,
    output logic       PREEMPT
);
    typedef enum logic {IDLE, GRANTED} state_t;
    state_t     state;
    logic [1:0] ptr;
    logic [1:0] pick;
    logic [3:0] rot;
    logic       drop;
    // Rotate requests so bit 0 is the requester at ptr, then take the first set bit.
    always_comb begin
        rot  = 4'({REQUEST, REQUEST} >> ptr);
        pick = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    end
`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_HOLD - 1);
    logic [CNT_WIDTH-1:0] cnt;
    logic                 limit;
    assign limit = (cnt == CNT_MAX) && |(REQUEST & ~GRANT);
    assign drop  = !REQUEST[SELECT] || limit;
`else
    assign drop    = !REQUEST[SELECT];
    assign PREEMPT = 1'b0;
`endif
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            GRANT  <= 4'b0000;
            SELECT <= 2'd0;
            BUSY   <= 1'b0;
            ptr    <= 2'd0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt     <= '0;
            PREEMPT <= 1'b0;
`endif
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            PREEMPT <= 1'b0;
`endif
            if (state == IDLE) begin
                if (|REQUEST) begin
                    state  <= GRANTED;
                    GRANT  <= 4'b0001 << pick;
                    SELECT <= pick;
                    BUSY   <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                    cnt    <= '0;
`endif
                end
            end else if (drop) begin
                state <= IDLE;
                GRANT <= 4'b0000;
                BUSY  <= 1'b0;
                ptr   <= SELECT + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
                // A genuine release wins over the limit, so only a still-requesting owner is preempted.
                PREEMPT <= REQUEST[SELECT];
`endif
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed self-checking bench for rr_arbiter_4.
// With ARB_HOLD_LIMIT_EN defined the DUT is built with MAX_HOLD=4.
module tb_rr_arbiter_4;
    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] REQUEST;
    logic [3:0] GRANT;
    logic [1:0] SELECT;
    logic       BUSY;
    logic       PREEMPT;
    int         total = 0;
    int         bad = 0;

`ifdef ARB_HOLD_LIMIT_EN
    rr_arbiter_4 #(.MAX_HOLD(4), .CNT_WIDTH(4)) dut (
`else
    rr_arbiter_4 dut (
`endif
        .CLK(CLK), .RESET(RESET), .REQUEST(REQUEST), .GRANT(GRANT),
        .SELECT(SELECT), .BUSY(BUSY), .PREEMPT(PREEMPT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic p);
        chk({tag, ".grant"}, GRANT, g);
        chk({tag, ".select"}, {2'b00, SELECT}, {2'b00, s});
        chk({tag, ".busy"}, {3'b000, BUSY}, {3'b000, b});
        chk({tag, ".preempt"}, {3'b000, PREEMPT}, {3'b000, p});
    endtask

    initial begin
        RESET   = 1'b0;
        REQUEST = 4'b1111;
        tick();
        tick();
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        RESET = 1'b1;
        tick();
        chk_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        // Rotation: each owner holds 3 cycles then drops its bit for one edge.
        for (int k = 0; k < 5; k++) begin
            chk_all("rot_grant", 4'b0001 << (k % 4), 2'(k % 4), 1'b1, 1'b0);
            tick();
            tick();
            chk("rot_hold", GRANT, 4'b0001 << (k % 4));
            REQUEST = 4'b1111 & ~(4'b0001 << (k % 4));
            tick();
            chk_all("rot_gap", 4'b0000, 2'(k % 4), 1'b0, 1'b0);
            REQUEST = 4'b1111;
            tick();
        end
        chk_all("rot_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        // Owner 1 releases, 2 granted; owner 2 releases leaving ptr=3 with 0011 pending.
        REQUEST = 4'b0100;
        tick();
        chk("wrap_gap1", GRANT, 4'b0000);
        tick();
        chk("wrap_own2", GRANT, 4'b0100);
        REQUEST = 4'b0011;
        tick();
        chk("wrap_gap2", GRANT, 4'b0000);
        tick();
        chk_all("wrap_to0", 4'b0001, 2'd0, 1'b1, 1'b0);
        REQUEST = 4'b0010;
        tick();
        tick();
        chk_all("skip_to1", 4'b0010, 2'd1, 1'b1, 1'b0);
        // Owner 1 releases and re-requests at once: 0 is ahead of it now.
        REQUEST = 4'b0001;
        tick();
        REQUEST = 4'b0011;
        tick();
        chk_all("behind", 4'b0001, 2'd0, 1'b1, 1'b0);
        REQUEST = 4'b0000;
        tick();
        tick();
        chk_all("idle_hold_sel", 4'b0000, 2'd0, 1'b0, 1'b0);
        REQUEST = 4'b0001;
        tick();
        chk("sole_regrant", GRANT, 4'b0001);
        // Reset mid-grant with owner 2; ptr was 1 before reset.
        REQUEST = 4'b0100;
        tick();
        tick();
        chk_all("pre_reset_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
        RESET = 1'b0;
        tick();
        chk_all("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        RESET   = 1'b1;
        REQUEST = 4'b0101;
        tick();
        chk_all("ptr_restart", 4'b0001, 2'd0, 1'b1, 1'b0);
        REQUEST = 4'b0100;
        tick();
        tick();
        chk_all("post_reset_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
        REQUEST = 4'b0000;
        tick();
        tick();
        REQUEST = 4'b0011;
        tick();
        chk_all("hold_start", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("hold_cycles", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        chk_all("preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_all("after_preempt", 4'b0010, 2'd1, 1'b1, 1'b0);
        REQUEST = 4'b0001;
        tick();
        tick();
        chk("sole_grant", GRANT, 4'b0001);
        for (int i = 0; i < 22; i++) begin
            tick();
            chk_all("sole_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        // Counter saturated; release coinciding with a pending rival is a plain release.
        REQUEST = 4'b0010;
        tick();
        chk_all("release_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 22; i++) begin
            tick();
            chk_all("no_limit_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one 4:1-muxed resource among four requesters, e.g. a shared register-file write port or a shared memory port.
- Drives the 2-bit SELECT of the existing 4-to-1 mux and returns a one-hot grant to each requester.
- Sequential block: a grant FSM, a rotating priority pointer, and an optional hold-limit counter that stops any one requester starving the others.

Parameters:
- MAX_HOLD, default 8: maximum consecutive granted cycles for one owner while others wait. Used only with ARB_HOLD_LIMIT_EN. Legal range 1..(2^CNT_WIDTH).
- CNT_WIDTH, default 4: width of the hold counter.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- REQUEST  input  4  REQUEST[i]=1: requester i wants the resource. Held high for as long as ownership is wanted.
- GRANT  output  4  one-hot (or zero) grant, registered.
- SELECT  output  2  binary index of the current or most recent owner; feeds the mux SELECT. Registered.
- BUSY  output  1  1 while any grant is active.
- PREEMPT  output  1  one-cycle pulse when the hold limit revokes a grant. Tied 0 when ARB_HOLD_LIMIT_EN is undefined.

Behaviour:
- Reset: RESET=0 at a CLK edge forces:
  - state=IDLE, GRANT=4'b0000, SELECT=2'b00, BUSY=0, PREEMPT=0
  - priority pointer PTR=2'd0, hold counter=0
  - Reset overrides every other event, including mid-grant. A grant in progress is dropped with no PREEMPT.
- States: IDLE, GRANTED.
- IDLE:
  - At each edge, if REQUEST!=0, choose the first set bit scanning PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - Load GRANT with that one-hot bit, SELECT with its index, BUSY=1, counter=0; go to GRANTED.
  - If REQUEST==0, stay in IDLE. GRANT stays 0 and SELECT holds its last value.
  - Latency: a request sampled at edge n gives GRANT high after edge n (visible in cycle n+1).
- GRANTED (owner o = SELECT):
  - REQUEST[o]=1: keep the grant and increment the counter, saturating at MAX_HOLD-1.
  - REQUEST[o]=0 at an edge: GRANT=0, BUSY=0, PTR=o+1 (mod 4, 3 wraps to 0), go to IDLE.
  - Changes on non-owner REQUEST bits never affect the current grant.
- Handover gap: after a release there is at least one cycle with GRANT=0 before the next owner; the new grant appears one edge after the release edge. Consecutive grants never overlap. GRANT is never multi-hot.
- Ownership rules:
  - A requester that releases and re-requests immediately goes behind the other pending requesters, because PTR has moved past it.
  - A sole requester may be re-granted after the one-cycle gap.
- Simultaneous events:
  - Release and hold-limit at the same edge: treated as a normal release, PREEMPT=0.
  - All four REQUEST bits rising in the same cycle: the grant goes to index PTR.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- Defined: in GRANTED, when counter==MAX_HOLD-1, REQUEST[o]=1 and (REQUEST & ~GRANT)!=0 at an edge:
  - GRANT=0, BUSY=0, PTR=o+1, PREEMPT=1 for exactly one cycle, go to IDLE.
  - The owner must see its grant dropped and may keep REQUEST high; it re-competes normally.
  - If no other requester is pending, the owner keeps the grant and the counter stays saturated.
- Undefined: no counter logic is built, PREEMPT is constant 0, and an owner holds the grant indefinitely while REQUEST[o]=1.

Test Plan:
- Reset: RESET=0 for 2 cycles with REQUEST=4'b1111 -> GRANT=0, SELECT=0, BUSY=0, PREEMPT=0. Release RESET -> GRANT=4'b0001 one cycle later.
- Round-robin rotation: REQUEST=4'b1111, and each owner drops its bit for one cycle after 3 granted cycles -> grant order 0,1,2,3,0, SELECT=0,1,2,3,0, exactly one GRANT=0 cycle between owners.
- Pointer wrap and skip: PTR=3 (after owner 2 releases), REQUEST=4'b0011 -> GRANT=4'b0001. Then owner 0 releases with REQUEST=4'b0010 -> GRANT=4'b0010.
- Reset mid-grant: owner 2 granted, RESET=0 for one edge -> GRANT=0 next cycle. Afterwards REQUEST=4'b0100 -> GRANT=4'b0100 with PTR restarted at 0.
- Hold limit (ARB_HOLD_LIMIT_EN, MAX_HOLD=4): REQUEST=4'b0011 held, owner 0 -> GRANT[0] high for exactly 4 cycles, PREEMPT=1 for 1 cycle, 1 idle cycle, then GRANT=4'b0010. With REQUEST=4'b0001 alone, GRANT[0] holds 20+ cycles and PREEMPT stays 0.
- Macro undefined: same REQUEST=4'b0011 stimulus -> owner 0 holds the grant for 20+ cycles and PREEMPT stays 0.
